// File: rtl/serial_link_host.sv
// Host-side partner of the 7-phase, 12-bit serial wrapper: serialises request frames onto
// in_bits and reassembles the wrapper's 21-bit result from out_bits into a response stream.
module serial_link_host #(
    parameter int REQ_DEPTH = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        link_en,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [38:0] req_frame,
    output logic [11:0] in_bits,
    input  logic [11:0] out_bits,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [20:0] rsp_data,
    output logic        rsp_idle,
    output logic        rsp_overflow,
    output logic [15:0] frame_cnt
);
    localparam int REQ_AW = $clog2(REQ_DEPTH);
    localparam int RSP_AW = $clog2(RSP_DEPTH);
    localparam logic [2:0]      LAST_PHASE = 3'd6;
    localparam logic [REQ_AW:0] REQ_ONE    = 1;
    localparam logic [RSP_AW:0] RSP_ONE    = 1;

    typedef struct packed {
        logic        idle;
        logic [20:0] data;
    } rsp_entry_t;

    logic [2:0]  phase;
    logic        at_load;
    logic        at_push;

    assign at_load = (phase == LAST_PHASE);
    assign at_push = (phase == 3'd0);

    // ---------------- request FIFO ----------------
    logic [38:0]     req_mem [REQ_DEPTH];
    logic [REQ_AW:0] req_wr_ptr;
    logic [REQ_AW:0] req_rd_ptr;
    logic            req_empty;
    logic            req_full;
    logic            req_push;
    logic            req_pop;

    assign req_empty = (req_wr_ptr == req_rd_ptr);
    assign req_full  = (req_wr_ptr[REQ_AW] != req_rd_ptr[REQ_AW]) &&
                       (req_wr_ptr[REQ_AW-1:0] == req_rd_ptr[REQ_AW-1:0]);
    assign req_ready = !req_full;
    assign req_push  = req_valid && req_ready;
    // Frames are only taken at a frame boundary; an empty FIFO is never bypassed.
    assign req_pop   = at_load && link_en && !req_empty;

    // NOTE: FIFO storage has no reset; the reset pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (req_push) req_mem[req_wr_ptr[REQ_AW-1:0]] <= req_frame;
    end

    // ---------------- frame drive ----------------
    logic [38:0] next_frame;
    logic [26:0] cur_rest;      // W1..W3 fields of the frame being driven
    logic        cur_idle;
    logic        prev_idle;
    logic [11:0] lo;
    logic [11:0] in_bits_nxt;

    assign next_frame = req_pop ? req_mem[req_rd_ptr[REQ_AW-1:0]] : '0;

    always_comb begin
        // NOTE: default assigned first so every path drives in_bits_nxt and no latch is inferred.
        in_bits_nxt = '0;
        case (phase)
            3'd6:    in_bits_nxt = next_frame[38:27];
            3'd0:    in_bits_nxt = cur_rest[14:3];
            3'd1:    in_bits_nxt = cur_rest[26:15];
            3'd2:    in_bits_nxt = {9'b0, cur_rest[2:0]};
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase      <= '0;
            in_bits    <= '0;
            cur_rest   <= '0;
            cur_idle   <= 1'b1;
            prev_idle  <= 1'b1;
            lo         <= '0;
            frame_cnt  <= '0;
            req_wr_ptr <= '0;
            req_rd_ptr <= '0;
        end else begin
            phase   <= at_load ? 3'd0 : phase + 3'd1;
            in_bits <= in_bits_nxt;
            if (req_push) req_wr_ptr <= req_wr_ptr + REQ_ONE;
            if (req_pop)  req_rd_ptr <= req_rd_ptr + REQ_ONE;
            if (at_load) begin
                cur_rest  <= next_frame[26:0];
                cur_idle  <= !req_pop;
                prev_idle <= cur_idle;
                lo        <= out_bits;
            end
            if (at_push) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // ---------------- response FIFO ----------------
    rsp_entry_t      rsp_mem [RSP_DEPTH];
    rsp_entry_t      push_entry;
    rsp_entry_t      head_entry;
    logic [RSP_AW:0] rsp_wr_ptr;
    logic [RSP_AW:0] rsp_rd_ptr;
    logic            rsp_full;
    logic            rsp_pop;
    logic            rsp_write;
    logic            unused_out_hi;

    // The result spans the phase-6 word and the low 9 bits of the following phase-0 word.
    assign push_entry    = '{idle: prev_idle, data: {out_bits[8:0], lo}};
    assign unused_out_hi = &{1'b0, out_bits[11:9]};

    assign rsp_valid = (rsp_wr_ptr != rsp_rd_ptr);
    assign rsp_full  = (rsp_wr_ptr[RSP_AW] != rsp_rd_ptr[RSP_AW]) &&
                       (rsp_wr_ptr[RSP_AW-1:0] == rsp_rd_ptr[RSP_AW-1:0]);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_write = at_push && (!rsp_full || rsp_pop);

    assign head_entry = rsp_mem[rsp_rd_ptr[RSP_AW-1:0]];
    assign rsp_data   = head_entry.data;
    assign rsp_idle   = head_entry.idle;

    always_ff @(posedge clk) begin
        if (rsp_write) rsp_mem[rsp_wr_ptr[RSP_AW-1:0]] <= push_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_wr_ptr   <= '0;
            rsp_rd_ptr   <= '0;
            rsp_overflow <= 1'b0;
        end else begin
            if (rsp_write) rsp_wr_ptr <= rsp_wr_ptr + RSP_ONE;
            if (rsp_pop)   rsp_rd_ptr <= rsp_rd_ptr + RSP_ONE;
            if (at_push && rsp_full && !rsp_pop) rsp_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_link_host.sv
// Self-checking bench for serial_link_host: directed steps plus random traffic, checked every
// cycle against a queue-based model of the frame slots, request FIFO and response FIFO.
module tb_serial_link_host;
    localparam int REQ_DEPTH = 2;
    localparam int RSP_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        link_en;
    logic        req_valid;
    logic        req_ready;
    logic [38:0] req_frame;
    logic [11:0] in_bits;
    logic [11:0] out_bits;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [20:0] rsp_data;
    logic        rsp_idle;
    logic        rsp_overflow;
    logic [15:0] frame_cnt;

    serial_link_host #(.REQ_DEPTH(REQ_DEPTH), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .link_en      (link_en),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_frame    (req_frame),
        .in_bits      (in_bits),
        .out_bits     (out_bits),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_idle     (rsp_idle),
        .rsp_overflow (rsp_overflow),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: cycles since reset, frame slots and the two FIFOs as queues.
    int          m_cycle;
    logic [38:0] m_req_q[$];
    logic [21:0] m_rsp_q[$];   // {idle, data}
    logic [38:0] m_cur_frame;
    bit          m_cur_real;
    bit          m_prev_real;
    logic [11:0] m_lo;
    bit          m_ovf;
    int          m_fcnt;
    bit          rand_out;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    function automatic logic [38:0] make_frame(input logic [3:0] v, input logic [3:0] cmd,
                                               input logic [3:0] wd, input logic [5:0] a3,
                                               input logic [5:0] a2, input logic [5:0] a1,
                                               input logic [5:0] a0, input logic [2:0] mem);
        return {v, cmd, wd, a3, a2, a1, a0, mem};
    endfunction

    // Word driven during the given phase of a frame's 7-cycle slot.
    function automatic logic [11:0] frame_word(input logic [38:0] f, input int p);
        case (p)
            0:       return f[38:27];
            1:       return {f[14:9], f[8:3]};
            2:       return {f[26:21], f[20:15]};
            3:       return {9'b0, f[2:0]};
            default: return 12'h000;
        endcase
    endfunction

    task automatic model_reset();
        m_cycle     = 0;
        m_req_q.delete();
        m_rsp_q.delete();
        m_cur_frame = '0;
        m_cur_real  = 1'b0;
        m_prev_real = 1'b0;
        m_lo        = '0;
        m_ovf       = 1'b0;
        m_fcnt      = 0;
    endtask

    // Effect of the coming clock edge, from the inputs currently applied.
    task automatic model_edge();
        int          p;
        bit          do_pop;
        bit          acc;
        bit          rpop;
        logic [38:0] nf;
        p      = m_cycle % 7;
        do_pop = (p == 6) && link_en && (m_req_q.size() > 0);
        acc    = req_valid && (m_req_q.size() < REQ_DEPTH);
        rpop   = rsp_ready && (m_rsp_q.size() > 0);
        nf     = '0;
        if (do_pop) nf = m_req_q.pop_front();
        if (acc) m_req_q.push_back(req_frame);
        if (rpop) void'(m_rsp_q.pop_front());
        if (p == 6) begin
            m_lo        = out_bits;
            m_prev_real = m_cur_real;
            m_cur_real  = do_pop;
            m_cur_frame = nf;
        end
        if (p == 0) begin
            if (m_rsp_q.size() < RSP_DEPTH) m_rsp_q.push_back({!m_prev_real, out_bits[8:0], m_lo});
            else m_ovf = 1'b1;
            m_fcnt++;
        end
        m_cycle++;
    endtask

    task automatic check_outputs();
        check("in_bits", in_bits, frame_word(m_cur_frame, m_cycle % 7));
        check("req_ready", req_ready, m_req_q.size() < REQ_DEPTH);
        check("rsp_valid", rsp_valid, m_rsp_q.size() != 0);
        if (m_rsp_q.size() != 0) begin
            check("rsp_data", rsp_data, m_rsp_q[0][20:0]);
            check("rsp_idle", rsp_idle, m_rsp_q[0][21]);
        end
        check("rsp_overflow", rsp_overflow, m_ovf);
        check("frame_cnt", frame_cnt, 16'(m_fcnt));
    endtask

    task automatic tick();
        if (rand_out) out_bits = 12'($urandom);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_until_phase(input int p);
        for (int i = 0; i < 7 && (m_cycle % 7) != p; i++) tick();
    endtask

    // Called at a falling edge: asserts reset asynchronously, checks, releases a cycle later.
    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        check("rst_in_bits", in_bits, 12'h000);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_overflow", rsp_overflow, 1'b0);
        check("rst_frame_cnt", frame_cnt, 16'h0000);
        model_reset();
        req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [38:0] f0, f1, f2;
        int n_drained;
        reset_n   = 1'b1;
        link_en   = 1'b1;
        req_valid = 1'b0;
        req_frame = '0;
        out_bits  = '0;
        rsp_ready = 1'b0;
        rand_out  = 1'b1;
        model_reset();
        @(negedge clk);

        // Step 1: reset, then three idle frames.
        apply_reset();
        for (int i = 0; i < 21; i++) tick();
        check("t1_frame_cnt", frame_cnt, 16'd3);
        check("t1_first_rsp_idle", rsp_idle, 1'b1);

        // Step 2: one directed request; step 3: loopback result on out_bits.
        rsp_ready = 1'b1;
        run_until_phase(0);
        req_valid = 1'b1;
        req_frame = make_frame(4'h1, 4'h2, 4'hA, 6'h00, 6'h00, 6'h00, 6'h15, 3'b000);
        tick();
        req_valid = 1'b0;
        run_until_phase(0);
        check("t2_w0", in_bits, 12'h12A);
        tick();
        check("t2_w1", in_bits, 12'h015);
        run_until_phase(6);
        rand_out = 1'b0;
        out_bits = 12'hCDE;
        tick();
        out_bits = 12'h0AB;
        tick();
        rand_out = 1'b1;
        check("t3_rsp_valid", rsp_valid, 1'b1);
        check("t3_rsp_data", rsp_data, 21'h0ABCDE);
        check("t2_rsp_idle", rsp_idle, 1'b0);

        // Step 4: three back-to-back requests against a two-entry FIFO.
        f0 = 39'({$urandom(), $urandom()});
        f1 = 39'({$urandom(), $urandom()});
        f2 = 39'({$urandom(), $urandom()});
        run_until_phase(0);
        req_valid = 1'b1;
        req_frame = f0;
        tick();
        req_frame = f1;
        tick();
        check("t4_req_ready_full", req_ready, 1'b0);
        req_frame = f2;
        run_until_phase(0);
        check("t4_f0_w0", in_bits, f0[38:27]);
        check("t4_req_ready_again", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        run_until_phase(0);
        check("t4_f1_w0", in_bits, f1[38:27]);
        tick();
        run_until_phase(0);
        check("t4_f2_w0", in_bits, f2[38:27]);

        // Step 5: consumer stalls for five frames.
        for (int i = 0; i < 21; i++) tick();
        run_until_phase(2);
        rsp_ready = 1'b0;
        for (int i = 0; i < 35; i++) tick();
        check("t5_overflow", rsp_overflow, 1'b1);
        rsp_ready = 1'b1;
        n_drained = 0;
        for (int i = 0; i < 8; i++) begin
            if (!rsp_valid) break;
            n_drained++;
            tick();
        end
        check("t5_held_count", n_drained, 4);

        // Step 6: reset pulsed during phase 2 of a real frame.
        run_until_phase(0);
        req_valid = 1'b1;
        req_frame = 39'({$urandom(), $urandom()});
        tick();
        req_valid = 1'b0;
        run_until_phase(0);
        run_until_phase(2);
        apply_reset();
        rsp_ready = 1'b0;
        tick();
        check("t6_rsp_idle", rsp_idle, 1'b1);
        check("t6_frame_cnt", frame_cnt, 16'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_frame = 39'({$urandom(), $urandom()});
            rsp_ready = ($urandom_range(0, 3) != 0);
            link_en   = ($urandom_range(0, 7) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
